// File: rtl/kbit_pkg.sv
// Shared types and constants for the k-bit pattern generator.
// Holds the FSM state enum, default sizes and the final-pattern helper.
package kbit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CNT_W = 5;
   localparam int DEF_SEQ_W = 14;

   function automatic logic [63:0] low_ones(input int unsigned n);
      return (64'd1 << n) - 64'd1;
   endfunction

   // Highest word with n bits set in a w-bit field: the n ones packed at the top.
   function automatic logic [63:0] last_word(input int unsigned w, input int unsigned n);
      return low_ones(n) << (w - n);
   endfunction

endpackage

// File: rtl/lsb_index.sv
// Combinational trailing-zero encoder: index of the lowest set bit of vec.
// An all-zero input yields index 0.
module lsb_index #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]         vec,
   output logic [$clog2(WIDTH)-1:0] idx
);

   localparam int IDX_W = $clog2(WIDTH);

   always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/kbit_pattern_gen.sv
// Emits every WIDTH-bit word with exactly k bits set, ascending, on a valid/ready stream.
// Optional macro KPG_SEQ_EN adds the out_seq index port and its counter.
module kbit_pattern_gen
   import kbit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W,
   parameter int SEQ_W = DEF_SEQ_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] k,
   input  logic             abort,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_word,
   output logic             out_last,
   output logic             busy,
   output logic             err
`ifdef KPG_SEQ_EN
   ,
   output logic [SEQ_W-1:0] out_seq
`endif
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] K_MAX = CNT_W'(WIDTH);

   if (SEQ_W < 1) begin : g_bad_seq_w
      $error("SEQ_W must be at least 1");
   end

   state_t           state, state_nxt;
   logic [WIDTH-1:0] word, word_nxt;
   logic [WIDTH-1:0] last_pat, last_nxt;
   logic             err_nxt;
   logic             xfer;

   logic [WIDTH-1:0] c;
   logic [WIDTH:0]   r;
   logic [IDX_W-1:0] tz;

`ifdef KPG_SEQ_EN
   logic [SEQ_W-1:0] seq, seq_nxt;
`endif

   // Gosper's step: c isolates the lowest one, r ripples it upward, and the
   // displaced ones are right-justified by shifting instead of dividing by c.
   assign c = word & (~word + WIDTH'(1));
   assign r = {1'b0, word} + {1'b0, c};

   lsb_index #(.WIDTH(WIDTH)) u_lsb_index (
      .vec (c),
      .idx (tz)
   );

   assign out_valid = (state == EMIT);
   assign busy      = (state == EMIT);
   assign out_word  = word;
   assign out_last  = out_valid && (word == last_pat);
   assign xfer      = out_valid && out_ready;

   always_comb begin
      state_nxt = state;
      word_nxt  = word;
      last_nxt  = last_pat;
      err_nxt   = 1'b0;
`ifdef KPG_SEQ_EN
      seq_nxt   = seq;
`endif
      unique case (state)
         IDLE: begin
            if (start && !abort) begin
               if (k > K_MAX) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = EMIT;
                  word_nxt  = WIDTH'(low_ones(32'(k)));
                  last_nxt  = WIDTH'(last_word(WIDTH, 32'(k)));
               end
            end
         end
         EMIT: begin
            if (abort || (xfer && out_last)) begin
               state_nxt = IDLE;
`ifdef KPG_SEQ_EN
               seq_nxt   = '0;
`endif
            end else if (xfer) begin
               word_nxt = WIDTH'((((r ^ {1'b0, word}) >> 2) >> tz) | r);
`ifdef KPG_SEQ_EN
               seq_nxt  = seq + SEQ_W'(1);
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         word     <= '0;
         last_pat <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         word     <= word_nxt;
         last_pat <= last_nxt;
         err      <= err_nxt;
      end
   end

`ifdef KPG_SEQ_EN
   always_ff @(posedge clk) begin
      if (rst) seq <= '0;
      else     seq <= seq_nxt;
   end

   assign out_seq = seq;
`endif

endmodule

// File: tb/tb_kbit_pattern_gen.sv
// Directed bench for kbit_pattern_gen; checks out_seq too when KPG_SEQ_EN is defined.
module tb_kbit_pattern_gen;

   localparam int WIDTH = 16;
   localparam int CNT_W = 5;
   localparam int SEQ_W = 14;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] k;
   logic             abort;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_word;
   logic             out_last;
   logic             busy;
   logic             err;
`ifdef KPG_SEQ_EN
   logic [SEQ_W-1:0] out_seq;
`endif

   int checks = 0;
   int errors = 0;

   kbit_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SEQ_W(SEQ_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k         (k),
      .abort     (abort),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_word  (out_word),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err)
`ifdef KPG_SEQ_EN
      ,
      .out_seq   (out_seq)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int popcount16(input logic [15:0] w);
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(w[i]);
      return n;
   endfunction

   // Reference successor: smallest word above x with exactly kv ones.
   function automatic logic [15:0] next_pop(input logic [15:0] x, input int kv);
      int y = int'(x) + 1;
      while (y <= 16'hFFFF && popcount16(16'(y)) != kv) y++;
      return 16'(y);
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
   endtask

   task automatic do_start(input int kv);
      start = 1'b1;
      k     = CNT_W'(kv);
      tick();
      start = 1'b0;
   endtask

   // Consume a whole sequence, checking every visible word against the model.
   task automatic run_seq(input int kv, input bit rnd, input int exp_n,
                          output logic [15:0] first_w, output logic [15:0] final_w);
      logic [15:0] expw;
      logic [15:0] prev;
      logic [15:0] held;
      bit          was_stall;
      bit          seen;
      int          n;
      int          budget;
      expw      = 16'((32'd1 << kv) - 1);
      prev      = '0;
      held      = '0;
      was_stall = 1'b0;
      seen      = 1'b0;
      n         = 0;
      budget    = 0;
      first_w   = '0;
      final_w   = '0;
      do_start(kv);
      while (n < exp_n && budget < 40000) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         chk("seq_valid", 32'(out_valid), 32'd1);
         chk("seq_word", 32'(out_word), 32'(expw));
         chk("seq_last", 32'(out_last), 32'(n == exp_n - 1));
         chk("seq_popcount", 32'(popcount16(out_word)), 32'(kv));
`ifdef KPG_SEQ_EN
         chk("seq_index", 32'(out_seq), 32'(n));
`endif
         if (kv == 1)  chk("k1_hand", 32'(out_word), 32'd1 << n);
         if (kv == 15) chk("k15_hand", 32'(out_word), 32'(16'hFFFF ^ 16'(32'd1 << (15 - n))));
         if (was_stall) chk("stall_hold", 32'(out_word), 32'(held));
         if (!seen && n > 0) chk("ascending", 32'(out_word > prev), 32'd1);
         seen = 1'b1;
         if (n == 0) first_w = out_word;
         if (out_ready) begin
            final_w   = out_word;
            prev      = out_word;
            was_stall = 1'b0;
            seen      = 1'b0;
            n++;
            if (n < exp_n) expw = next_pop(expw, kv);
         end else begin
            was_stall = 1'b1;
            held      = out_word;
         end
         tick();
         budget++;
      end
      chk("seq_count", 32'(n), 32'(exp_n));
      out_ready = 1'b1;
      chk_idle("seq_end");
`ifdef KPG_SEQ_EN
      chk("seq_end_index", 32'(out_seq), 32'd0);
`endif
   endtask

   logic [15:0] fw;
   logic [15:0] lw;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      k         = '0;
      abort     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_word",  32'(out_word),  32'd0);
      chk("rst_last",  32'(out_last),  32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_err",   32'(err),       32'd0);
`ifdef KPG_SEQ_EN
      chk("rst_seq",   32'(out_seq),   32'd0);
`endif
      rst = 1'b0;
      tick();

      // k=0: single all-zero word flagged last
      do_start(0);
      chk("k0_valid", 32'(out_valid), 32'd1);
      chk("k0_word",  32'(out_word),  32'h0000);
      chk("k0_last",  32'(out_last),  32'd1);
      chk("k0_busy",  32'(busy),      32'd1);
      tick();
      chk_idle("k0_after");

      // k=16: single all-ones word, started on the first idle cycle
      do_start(16);
      chk("k16_word", 32'(out_word), 32'hFFFF);
      chk("k16_last", 32'(out_last), 32'd1);
      tick();
      chk_idle("k16_after");

      run_seq(1, 1'b0, 16, fw, lw);
      chk("k1_first", 32'(fw), 32'h0001);
      chk("k1_final", 32'(lw), 32'h8000);

      run_seq(15, 1'b0, 16, fw, lw);
      chk("k15_first", 32'(fw), 32'h7FFF);
      chk("k15_final", 32'(lw), 32'hFFFE);

      run_seq(8, 1'b1, 12870, fw, lw);
      chk("k8_first", 32'(fw), 32'h00FF);
      chk("k8_final", 32'(lw), 32'hFF00);

      // k=17 is out of range: one-cycle err, nothing emitted
      do_start(17);
      chk("k17_err",   32'(err),       32'd1);
      chk_idle("k17");
      tick();
      chk("k17_err_clear", 32'(err), 32'd0);
      chk_idle("k17_later");

      // abort and start together in IDLE: abort wins
      abort = 1'b1;
      do_start(3);
      abort = 1'b0;
      chk_idle("abort_start");
      chk("abort_start_err", 32'(err), 32'd0);

      // k=2 with abort after 5 transfers; a mid-sequence start is ignored
      do_start(2);
      chk("k2_w0", 32'(out_word), 32'h0003);
      tick();
      chk("k2_w1", 32'(out_word), 32'h0005);
      start = 1'b1;
      k     = CNT_W'(0);
      tick();
      start = 1'b0;
      chk("k2_w2", 32'(out_word), 32'h0006);
      tick();
      chk("k2_w3", 32'(out_word), 32'h0009);
      tick();
      chk("k2_w4", 32'(out_word), 32'h000A);
      tick();
      chk("k2_w5", 32'(out_word), 32'h000C);
      chk("k2_w5_last", 32'(out_last), 32'd0);
`ifdef KPG_SEQ_EN
      chk("k2_seq5", 32'(out_seq), 32'd5);
`endif
      out_ready = 1'b0;
      abort     = 1'b1;
      tick();
      abort     = 1'b0;
      out_ready = 1'b1;
      chk_idle("k2_abort");
`ifdef KPG_SEQ_EN
      chk("k2_abort_seq", 32'(out_seq), 32'd0);
`endif
      do_start(2);
      chk("k2_restart", 32'(out_word), 32'h0003);
      chk("k2_restart_valid", 32'(out_valid), 32'd1);

      // reset in the middle of a sequence
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_idle("midrst");
      chk("midrst_word", 32'(out_word), 32'd0);
      chk("midrst_last", 32'(out_last), 32'd0);
      rst = 1'b0;
      tick();
      chk_idle("midrst_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kbit_pattern_gen.md
Name: kbit_pattern_gen

Overview:
- Inverse of the popcount16 function: given a count k, emits every WIDTH-bit word with exactly k bits set.
- Words come out in strictly ascending numeric order, one per accepted handshake, on a valid/ready stream.
- Used as an exhaustive stimulus and pattern source for popcount datapaths. Its output feeds popcount16 directly as a self-check.

Parameters:
- WIDTH, 16, output word width.
- CNT_W, 5, width of k; must hold the value WIDTH.
- SEQ_W, 14, width of the sequence counter; must hold C(WIDTH, WIDTH/2) - 1 (12869 at WIDTH=16).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- k  in  CNT_W  requested bit count; sampled with start.
- abort  in  1  terminates an active sequence.
- out_ready  in  1  downstream ready.
- out_valid  out  1  out_word is valid.
- out_word  out  WIDTH  current pattern.
- out_last  out  1  qualifies the final word of the sequence.
- busy  out  1  high in EMIT.
- err  out  1  one-cycle pulse when a request has k > WIDTH.
- out_seq  out  SEQ_W  zero-based index of out_word; present only with KPG_SEQ_EN.

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high, on ports clk/rst.
- Reset values: state=IDLE; out_valid, out_last, busy and err at 0; out_word=0; out_seq=0.
- States are IDLE and EMIT.
- IDLE, start=1, k<=WIDTH: the next cycle enters EMIT with out_valid=1 and out_word=(1<<k)-1. Latency from start to first valid is 1 cycle.
- IDLE, start=1, k>WIDTH: err=1 for exactly one cycle. State stays IDLE and no word is emitted.
- Start while in EMIT is ignored.
- Handshake: a transfer occurs when out_valid && out_ready. While out_ready=0, out_word, out_last and out_seq hold stable.
- Next word on transfer, using Gosper's step:
  - c = x & -x
  - r = x + c
  - next = (((r ^ x) >> 2) >> tz(c)) | r
  - tz is the trailing-zero index. No divider is allowed.
  - The sum is computed WIDTH+1 bits wide so the carry is not lost.
- out_last=1 when out_word == ((1<<k)-1) << (WIDTH-k). This is precomputed at start.
- Transfer with out_last=1: return to IDLE next cycle, with out_valid and busy at 0.
- Back-to-back operation: a new start is accepted on the first IDLE cycle.
- k=0: one word, 0x0000, with out_last=1.
- k=WIDTH: one word, 0xFFFF, with out_last=1.
- abort in EMIT: next cycle is IDLE with out_valid=0. Any transfer in the abort cycle still counts downstream.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- rst mid-sequence: the next cycle shows reset values. No partial word is emitted.
- Throughput is one word per cycle with out_ready held high.

Optional Feature:
- Macro KPG_SEQ_EN.
- Defined: the out_seq port exists. It is 0 on the first word and increments on each transfer. It holds under stall and clears on return to IDLE.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package kbit_pkg holds:
  - the state enum (IDLE, EMIT);
  - the defaults WIDTH=16, CNT_W=5 and SEQ_W=14;
  - a function for the final-pattern constant.
- One sub-module, lsb_index: a combinational WIDTH-bit trailing-zero encoder producing tz(c). Its output width is $clog2(WIDTH).

Test Plan:
- start k=0, ready=1 -> one word 0x0000 with last=1 one cycle after start; busy low the cycle after the transfer.
- start k=1, ready=1 -> 16 consecutive words 0x0001, 0x0002, ... 0x8000; last only on 0x8000.
- start k=15, ready=1 -> 16 words: 0x7FFF, 0xBFFF, 0xDFFF, ... 0xFFFE; last on 0xFFFE.
- start k=8, random out_ready -> 12870 words:
  - first 0x00FF, last 0xFF00;
  - each word has popcount 8, checked by popcount16;
  - the sequence is strictly increasing;
  - word is stable during stalls;
  - with KPG_SEQ_EN, out_seq runs 0..12869.
- start k=17 -> err high for exactly 1 cycle; out_valid and busy stay 0.
- start k=2, abort after 5 transfers -> out_valid=0 next cycle. A start pulsed mid-sequence is ignored. A fresh start k=2 restarts at 0x0003.
